// File: rtl/serdesphy_pkg.sv
// Shared Manchester/biphase definitions for the SERDES PHY.
// Holds the decoder FSM encoding, the symbol constants used by both the TX
// biphase encoder and the RX decoder, and the pair encode/decode helpers.
package serdesphy_pkg;

  localparam int MAN_WORD_W = 16;
  localparam int DATA_W     = 8;

  // 2-bit state encoding; 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DECODE = 2'b01,
    ST_OUTPUT = 2'b10
  } state_t;

  // Symbols written as {hi,lo}, hi being the first half-bit on the line.
  localparam logic [1:0] MAN_ONE  = 2'b01;
  localparam logic [1:0] MAN_ZERO = 2'b10;

  // TX side: one data bit to its two-half-bit symbol.
  function automatic logic [1:0] man_encode_bit(input logic dbit);
    return dbit ? MAN_ONE : MAN_ZERO;
  endfunction

  // RX side: returns {bit, err}. Invalid pairs ("00"/"11") still yield lo as
  // the bit so the byte is defined, but raise err.
  function automatic logic [1:0] man_decode_pair(input logic [1:0] sym);
    logic dbit;
    logic err;
    case (sym)
      MAN_ONE: begin
        dbit = 1'b1;
        err  = 1'b0;
      end
      MAN_ZERO: begin
        dbit = 1'b0;
        err  = 1'b0;
      end
      default: begin
        dbit = sym[0];
        err  = 1'b1;
      end
    endcase
    return {dbit, err};
  endfunction

endpackage

// File: rtl/serdesphy_manchester_decoder_if.sv
// Handshake bundle between the RX deserializer, the Manchester decoder and
// the downstream byte consumer. master = environment, slave = decoder.
interface serdesphy_manchester_decoder_if;
  import serdesphy_pkg::*;

  logic [MAN_WORD_W-1:0] manchester_data;
  logic                  manchester_valid;
  logic                  manchester_ready;
  logic [DATA_W-1:0]     data_out;
  logic                  data_valid;
  logic                  data_ready;
  logic                  code_error;

  modport master (
    output manchester_data,
    output manchester_valid,
    input  manchester_ready,
    input  data_out,
    input  data_valid,
    output data_ready,
    input  code_error
  );

  modport slave (
    input  manchester_data,
    input  manchester_valid,
    output manchester_ready,
    output data_out,
    output data_valid,
    input  data_ready,
    output code_error
  );

endinterface

// File: rtl/serdesphy_manchester_decoder.sv
// RX Manchester decoder: takes a 16-bit biphase word, recovers 8 data bits,
// flags invalid symbol pairs and keeps a saturating code-error counter.
// Three-state flow IDLE -> DECODE -> OUTPUT, so at most one word per 3 clocks.
//
// Build option SERDESPHY_MANCHESTER_DROP_ERR_EN: errored words are counted
// but never delivered (DECODE returns straight to IDLE) and code_error is 0.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | ready for a word; captures manchester_data on valid
//   ST_DECODE | decodes the captured word, registers byte and error flag
//   ST_OUTPUT | presents data_valid until data_ready is seen
module serdesphy_manchester_decoder
  import serdesphy_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  serdesphy_manchester_decoder_if.slave bus,
  output logic [ERR_CNT_W-1:0]         error_count,
  input  logic                         error_clear
);

  state_t                state_q;
  state_t                state_d;
  logic [MAN_WORD_W-1:0] word_q;
  logic [DATA_W-1:0]     data_q;
  logic [DATA_W-1:0]     dec_byte;
  logic [DATA_W-1:0]     dec_err_vec;
  logic                  dec_err;

  // Eight parallel pair decoders over the captured word.
  for (genvar g = 0; g < DATA_W; g++) begin : g_pair
    logic [1:0] res;
    assign res            = man_decode_pair(word_q[2*g +: 2]);
    assign dec_byte[g]    = res[1];
    assign dec_err_vec[g] = res[0];
  end

  assign dec_err = |dec_err_vec;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.manchester_valid) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
`ifdef SERDESPHY_MANCHESTER_DROP_ERR_EN
        state_d = dec_err ? ST_IDLE : ST_OUTPUT;
`else
        state_d = ST_OUTPUT;
`endif
      end
      ST_OUTPUT: begin
        if (bus.data_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Word capture in IDLE and decoded-byte register loaded in DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      data_q <= '0;
    end else begin
      if (state_q == ST_IDLE && bus.manchester_valid) begin
        word_q <= bus.manchester_data;
      end
      if (state_q == ST_DECODE) begin
        data_q <= dec_byte;
      end
    end
  end

`ifdef SERDESPHY_MANCHESTER_DROP_ERR_EN
  assign bus.code_error = 1'b0;
`else
  logic code_error_q;

  // Error flag travels with the byte it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_error_q <= 1'b0;
    end else if (state_q == ST_DECODE) begin
      code_error_q <= dec_err;
    end
  end

  assign bus.code_error = code_error_q;
`endif

  // Saturating count of errored words; a clear wins over a same-cycle bump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_count <= '0;
    end else if (error_clear) begin
      error_count <= '0;
    end else if (state_q == ST_DECODE && dec_err && !(&error_count)) begin
      error_count <= error_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.manchester_ready = (state_q == ST_IDLE);
  assign bus.data_valid       = (state_q == ST_OUTPUT);
  assign bus.data_out         = data_q;

endmodule

// File: tb/tb_serdesphy_manchester_decoder.sv
// Directed bench for the Manchester decoder. Stimulus pushes the expected
// {code_error, byte} into a queue; a monitor pops and compares on every
// data_valid && data_ready handshake. Built with a 2-bit error counter so
// saturation is reachable quickly.
module tb_serdesphy_manchester_decoder;

  localparam int CW = 2;
`ifdef SERDESPHY_MANCHESTER_DROP_ERR_EN
  localparam logic DROP = 1'b1;
`else
  localparam logic DROP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          error_clear = 1'b0;
  logic [CW-1:0] error_count;

  serdesphy_manchester_decoder_if bus ();

  serdesphy_manchester_decoder #(
    .ERR_CNT_W (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .error_count (error_count),
    .error_clear (error_clear)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         exp_cnt = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare every delivered byte against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.data_valid && bus.data_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected actual=%0h required=none", bus.data_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_data", {24'h0, bus.data_out}, {24'h0, mon_e[7:0]});
          check("sb_code_error", {31'h0, bus.code_error}, {31'h0, mon_e[8]});
        end
      end
    end
  end

  // Send one word, check handshake timing and the error counter.
  task automatic send(input logic [15:0] w, input logic [7:0] b, input logic err,
                      input logic clr);
    logic deliver;
    int   n;
    deliver = !(DROP && err);
    if (deliver) exp_q.push_back({err & ~DROP, b});
    @(posedge clk); #1;
    bus.manchester_data  = w;
    bus.manchester_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.manchester_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'h0, bus.manchester_ready}, 32'd1);
    @(posedge clk); #1;
    bus.manchester_valid = 1'b0;
    error_clear = clr;
    if (clr) exp_cnt = 0;
    else if (err) exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
    @(negedge clk);
    check("decode_ready_low", {31'h0, bus.manchester_ready}, 32'd0);
    check("decode_valid_low", {31'h0, bus.data_valid}, 32'd0);
    @(posedge clk); #1;
    error_clear = 1'b0;
    @(negedge clk);
    check("latency_valid", {31'h0, bus.data_valid}, {31'h0, deliver});
    check("output_ready", {31'h0, bus.manchester_ready}, {31'h0, ~deliver});
    check("error_count", {30'h0, error_count}, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.manchester_data  = '0;
    bus.manchester_valid = 1'b0;
    bus.data_ready       = 1'b1;
    #12;
    check("rst_ready", {31'h0, bus.manchester_ready}, 32'd1);
    check("rst_valid", {31'h0, bus.data_valid}, 32'd0);
    check("rst_data", {24'h0, bus.data_out}, 32'd0);
    check("rst_code_error", {31'h0, bus.code_error}, 32'd0);
    check("rst_error_count", {30'h0, error_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // all "01" pairs, then data_valid for exactly one cycle
    send(16'h5555, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    check("valid_one_cycle", {31'h0, bus.data_valid}, 32'd0);

    // back-to-back words
    send(16'hAAAA, 8'h00, 1'b0, 1'b0);
    send(16'h6996, 8'h96, 1'b0, 1'b0);

    // pair 0 = "11"
    send(16'h5557, 8'hFF, 1'b1, 1'b0);

    // downstream stall: byte held, next word not taken
    @(posedge clk); #1;
    bus.data_ready = 1'b0;
    send(16'h9999, 8'h55, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.manchester_data  = 16'h5555;
    bus.manchester_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'h0, bus.data_valid}, 32'd1);
      check("stall_data", {24'h0, bus.data_out}, 32'h55);
      check("stall_ready", {31'h0, bus.manchester_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.data_ready       = 1'b1;
    bus.manchester_valid = 1'b0;
    @(negedge clk);
    check("release_ready", {31'h0, bus.manchester_ready}, 32'd0);
    @(negedge clk);
    check("release_idle", {31'h0, bus.manchester_ready}, 32'd1);
    check("release_valid", {31'h0, bus.data_valid}, 32'd0);

    // saturation of the 2-bit counter, then clear beating an increment
    @(posedge clk); #1;
    error_clear = 1'b1;
    @(posedge clk); #1;
    error_clear = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    check("clear_count", {30'h0, error_count}, 32'd0);
    send(16'h5557, 8'hFF, 1'b1, 1'b0);
    send(16'h0000, 8'h00, 1'b1, 1'b0);
    send(16'hFFFF, 8'hFF, 1'b1, 1'b0);
    send(16'hAAAB, 8'h01, 1'b1, 1'b0);
    send(16'h5554, 8'hFE, 1'b1, 1'b0);
    check("saturated", {30'h0, error_count}, 32'd3);
    send(16'h1555, 8'h7F, 1'b1, 1'b1);

    // asynchronous reset while a byte is on offer
    send(16'h5557, 8'hFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    bus.data_ready = 1'b0;
    send(16'h5555, 8'hFF, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'h0, bus.data_valid}, 32'd0);
    check("arst_error_count", {30'h0, error_count}, 32'd0);
    check("arst_data", {24'h0, bus.data_out}, 32'd0);
    check("arst_code_error", {31'h0, bus.code_error}, 32'd0);
    check("arst_ready", {31'h0, bus.manchester_ready}, 32'd1);
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.data_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_valid", {31'h0, bus.data_valid}, 32'd0);
      check("post_rst_ready", {31'h0, bus.manchester_ready}, 32'd1);
    end
    send(16'h6996, 8'h96, 1'b0, 1'b0);
    @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
